// File: rtl/display_fb_reader.sv
// Framebuffer reader: fetches one frame in fixed-length bursts into a pixel FIFO
// and streams it to the display path over valid/ready.
module display_fb_reader #(
  parameter logic [31:0] FB_BASE    = 32'h0000_0000,
  parameter int unsigned LINE_WORDS = 320,
  parameter int unsigned LINES      = 240,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        frame_start,
  output logic        rd_req_valid,
  input  logic        rd_req_ready,
  output logic [31:0] rd_req_addr,
  output logic [7:0]  rd_req_len,
  input  logic        rd_data_valid,
  input  logic [31:0] rd_data,
  output logic        display_valid,
  input  logic        display_ready,
  output logic [31:0] display_data,
  output logic        busy,
  output logic        frame_done,
  output logic        underflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  localparam logic [31:0] TOTAL     = 32'(LINE_WORDS * LINES);
  localparam logic [31:0] ADDR_STEP = 32'(4 * BURST_LEN);
  localparam logic [31:0] BURST_W   = 32'(BURST_LEN);
  localparam logic [7:0]  LAST_BEAT = 8'(BURST_LEN - 1);
  // Highest fill level that still leaves room for a whole burst.
  localparam cnt_t        MAX_FILL  = cnt_t'(FIFO_DEPTH - BURST_LEN);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] req_rem_q, req_rem_d;
  logic [31:0] pop_rem_q, pop_rem_d;
  logic [7:0]  beat_q, beat_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        underflow_q, underflow_d;
  ptr_t        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t        count_q, count_d;
  logic [31:0] mem [FIFO_DEPTH];

  logic start, push, pop, req_fire;

  assign start         = (state_q == ST_IDLE) & enable & frame_start;
  assign push          = (state_q == ST_WAIT) & rd_data_valid;
  assign display_valid = (count_q != '0);
  assign pop           = display_valid & display_ready;
  assign rd_req_valid  = (state_q == ST_REQ) & (count_q <= MAX_FILL);
  assign req_fire      = rd_req_valid & rd_req_ready;

  assign rd_req_addr  = addr_q;
  assign rd_req_len   = 8'(BURST_LEN);
  assign display_data = display_valid ? mem[rd_ptr_q] : '0;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign underflow    = underflow_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    req_rem_d    = req_rem_q;
    pop_rem_d    = pop_rem_q;
    beat_d       = beat_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    underflow_d  = underflow_q;

    if (busy_q && display_ready && !display_valid) underflow_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = FB_BASE;
          req_rem_d   = TOTAL;
          pop_rem_d   = TOTAL;
          beat_d      = '0;
          underflow_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (req_fire) begin
          addr_d    = addr_q + ADDR_STEP;
          req_rem_d = req_rem_q - BURST_W;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (push) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = (req_rem_q != '0) ? ST_REQ : ST_DRAIN;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: ;
    endcase

    // The final pop ends the frame from whatever state it lands in.
    if (pop && busy_q) begin
      pop_rem_d = pop_rem_q - 32'd1;
      if (pop_rem_q == 32'd1) begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (start) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      if (push && !pop)      count_d = count_q + cnt_t'(1);
      else if (pop && !push) count_d = count_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      req_rem_q    <= '0;
      pop_rem_q    <= '0;
      beat_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underflow_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      req_rem_q    <= req_rem_d;
      pop_rem_q    <= pop_rem_d;
      beat_q       <= beat_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      underflow_q  <= underflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= rd_data;
  end

endmodule

// File: tb/tb_display_fb_reader.sv
// Randomized bench for display_fb_reader: a memory responder returns data = address and a
// transaction-level model predicts requests, pixel order, frame end and underflow.
module tb_display_fb_reader;

  localparam logic [31:0] BASE  = 32'h1000;
  localparam int          LW    = 4;
  localparam int          NL    = 4;
  localparam int          BL    = 4;
  localparam int          DEPTH = 8;
  localparam int          TOTAL = LW * NL;
  localparam int          NB    = TOTAL / BL;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        frame_start = 1'b0;
  logic        rd_req_ready = 1'b0;
  logic        rd_data_valid = 1'b0;
  logic [31:0] rd_data = '0;
  logic        display_ready = 1'b0;
  logic        rd_req_valid;
  logic [31:0] rd_req_addr;
  logic [7:0]  rd_req_len;
  logic        display_valid;
  logic [31:0] display_data;
  logic        busy;
  logic        frame_done;
  logic        underflow;

  always #5 clk = ~clk;

  display_fb_reader #(
    .FB_BASE   (BASE),
    .LINE_WORDS(LW),
    .LINES     (NL),
    .BURST_LEN (BL),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .frame_start  (frame_start),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_req_len   (rd_req_len),
    .rd_data_valid(rd_data_valid),
    .rd_data      (rd_data),
    .display_valid(display_valid),
    .display_ready(display_ready),
    .display_data (display_data),
    .busy         (busy),
    .frame_done   (frame_done),
    .underflow    (underflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame-level model: counts of bursts issued/finished and words pushed/popped.
  bit m_busy, m_under, m_fdone;
  int m_issued, m_done_b, m_beats, m_pushed, m_popped;

  // Memory responder state.
  logic [31:0] mq[$];
  int m_beat_idx = 0;
  int m_delay    = 0;

  // Stimulus knobs.
  int pct_req = 100, pct_disp = 100, pct_beat = 100, dly_min = 0, dly_max = 0;
  int stall_left = 0;

  task automatic model_reset();
    m_busy = 0; m_under = 0; m_fdone = 0;
    m_issued = 0; m_done_b = 0; m_beats = 0; m_pushed = 0; m_popped = 0;
  endtask

  function automatic bit exp_req_valid();
    int occ = m_pushed - m_popped;
    return m_busy && (m_issued == m_done_b) && (m_issued < NB) && (occ <= DEPTH - BL);
  endfunction

  task automatic compare_outputs();
    int occ = m_pushed - m_popped;
    bit er  = exp_req_valid();
    check("req_valid", rd_req_valid, er);
    if (er) check("req_addr", rd_req_addr, BASE + 32'(16 * m_issued));
    check("req_len", rd_req_len, 32'(BL));
    check("disp_valid", display_valid, occ > 0);
    if (occ > 0) check("disp_data", display_data, BASE + 32'(4 * m_popped));
    check("busy", busy, m_busy);
    check("frame_done", frame_done, m_fdone);
    check("underflow", underflow, m_under);
  endtask

  // One clock: drive inputs, predict the edge, then compare #1 after it.
  task automatic cycle(input bit start_pulse, input bit en);
    int          occ;
    bit          er, start_acc, push, pop, hs_dut;
    logic [31:0] hs_addr;
    frame_start   = start_pulse;
    enable        = en;
    rd_req_ready  = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < pct_req);
    display_ready = ($urandom_range(99) < pct_disp);
    if (mq.size() > 0 && m_delay == 0 && $urandom_range(99) < pct_beat) begin
      rd_data_valid = 1'b1;
      rd_data       = mq[0] + 32'(4 * m_beat_idx);
    end else begin
      rd_data_valid = 1'b0;
      rd_data       = $urandom;
    end
    occ       = m_pushed - m_popped;
    er        = exp_req_valid();
    start_acc = !m_busy && en && start_pulse;
    push      = m_busy && (m_issued > m_done_b) && rd_data_valid;
    pop       = (occ > 0) && display_ready;
    hs_dut    = rd_req_valid && rd_req_ready;
    hs_addr   = rd_req_addr;
    @(posedge clk);
    m_fdone = 0;
    if (m_busy && display_ready && occ == 0) m_under = 1;
    if (start_acc) begin
      model_reset();
      m_busy = 1;
    end
    if (er && rd_req_ready) m_issued++;
    if (push) begin
      m_pushed++;
      m_beats++;
      if (m_beats == BL) begin
        m_beats = 0;
        m_done_b++;
      end
    end
    if (pop) begin
      m_popped++;
      if (m_popped == TOTAL) begin
        m_fdone = 1;
        m_busy  = 0;
      end
    end
    if (rd_data_valid) begin
      m_beat_idx++;
      if (m_beat_idx == BL) begin
        void'(mq.pop_front());
        m_beat_idx = 0;
        m_delay    = int'($urandom_range(dly_max, dly_min));
      end
    end else if (mq.size() > 0 && m_delay > 0) begin
      m_delay--;
    end
    if (hs_dut) begin
      if (mq.size() == 0) m_delay = int'($urandom_range(dly_max, dly_min));
      mq.push_back(hs_addr);
    end
    if (stall_left > 0) stall_left--;
    #1;
    compare_outputs();
  endtask

  task automatic finish_frame(input int junk_pct);
    int budget = 3000;
    while (m_busy && budget > 0) begin
      cycle($urandom_range(99) < junk_pct, (junk_pct == 0) ? 1'b1 : 1'($urandom_range(1)));
      budget--;
    end
    check("frame_pops", 32'(m_popped), 32'(TOTAL));
    check("frame_end_busy", busy, 1'b0);
    cycle(1'b0, 1'b1);
  endtask

  task automatic run_frame(input int junk_pct);
    cycle(1'b1, 1'b1);
    finish_frame(junk_pct);
  endtask

  task automatic do_reset();
    int budget = 200;
    reset_n = 1'b0;
    #1;
    check("rst_req_valid", rd_req_valid, 1'b0);
    check("rst_req_addr", rd_req_addr, 32'h0);
    check("rst_req_len", rd_req_len, 32'(BL));
    check("rst_disp_valid", display_valid, 1'b0);
    check("rst_disp_data", display_data, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_underflow", underflow, 1'b0);
    model_reset();
    repeat (2) cycle(1'b0, 1'b1);
    reset_n = 1'b1;
    // Let the abandoned burst's stray beats arrive while idle.
    while (mq.size() > 0 && budget > 0) begin
      cycle(1'b0, 1'b1);
      budget--;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Basic frame, everything ready.
    run_frame(0);

    // Request stall: ready withheld for 5 cycles after the request appears.
    stall_left = 6;
    run_frame(0);

    // Display backpressure: FIFO fills to two bursts, no third request.
    pct_disp = 0;
    cycle(1'b1, 1'b1);
    repeat (30) cycle(1'b0, 1'b1);
    check("bp_no_req", rd_req_valid, 1'b0);
    check("bp_fifo_full", display_valid, 1'b1);
    pct_disp = 100;
    finish_frame(0);

    // Underflow: slow memory with an eager display.
    dly_min = 10; dly_max = 10;
    run_frame(0);
    check("uf_sticky", underflow, 1'b1);
    dly_min = 0; dly_max = 0;
    cycle(1'b1, 1'b1);
    check("uf_cleared", underflow, 1'b0);
    finish_frame(0);

    // Ignored starts: while busy and with enable low.
    cycle(1'b1, 1'b0);
    check("start_disabled", busy, 1'b0);
    run_frame(40);

    // Reset after two beats of the first burst.
    cycle(1'b1, 1'b1);
    begin
      int budget = 50;
      while (m_pushed < 2 && budget > 0) begin
        cycle(1'b0, 1'b1);
        budget--;
      end
    end
    do_reset();
    run_frame(0);

    // Randomized traffic.
    repeat (10) begin
      pct_req  = int'($urandom_range(100, 30));
      pct_disp = int'($urandom_range(100, 20));
      pct_beat = int'($urandom_range(100, 40));
      dly_min  = 0;
      dly_max  = int'($urandom_range(5, 0));
      run_frame(10);
    end

    frame_start = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_fb_reader.md
# display_fb_reader

Streams one frame of 32-bit pixel words from a framebuffer in memory into the display controller's pixel input. On a frame start it issues fixed-length burst read requests to the memory read port and buffers the returned words in an internal FIFO. It then presents them to the display path over a valid/ready handshake. It sits between the memory fabric and `display_controller`, and feeds its `display_data_in`.

## Interface
- `FB_BASE`, default 32'h0000_0000: byte address of the first pixel word.
- `LINE_WORDS`, default 320: 32-bit words per line.
- `LINES`, default 240: lines per frame.
- `BURST_LEN`, default 16: words per read burst, 1..255. `LINE_WORDS*LINES` must be a multiple of `BURST_LEN`.
- `FIFO_DEPTH`, default 64: pixel FIFO entries. Power of two, ≥ `BURST_LEN`.
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: block enable. When low, `frame_start` is ignored.
- `frame_start` in 1: one-cycle pulse that starts a frame fetch.
- `rd_req_valid` out 1: burst read request valid.
- `rd_req_ready` in 1: memory accepts the request.
- `rd_req_addr` out 32: byte address of the burst.
- `rd_req_len` out 8: burst length in words. Always equals `BURST_LEN`.
- `rd_data_valid` in 1: read data beat. There is no backpressure on this interface.
- `rd_data` in 32: read data word.
- `display_valid` out 1: FIFO head word is available.
- `display_ready` in 1: display path accepts the word.
- `display_data` out 32: FIFO head word, first-word fall-through.
- `busy` out 1: a frame fetch or drain is in progress.
- `frame_done` out 1: one-cycle pulse when the last word of the frame is popped.
- `underflow` out 1: sticky flag, set when the display requests a word and the FIFO is empty mid-frame.

## Operation
- **State machine: IDLE, REQ, WAIT, DRAIN.**
- **IDLE:** on `frame_start & enable`:
  - load address = `FB_BASE`;
  - load words-remaining-to-request = `LINE_WORDS*LINES`;
  - load words-remaining-to-pop = same value;
  - clear `underflow`, set `busy`, go to REQ.
- **REQ:** `rd_req_valid` is high only while free FIFO slots (`FIFO_DEPTH - count`) ≥ `BURST_LEN`.
  - Once asserted, `rd_req_valid`, `rd_req_addr` and `rd_req_len` stay stable until `rd_req_ready`.
  - On handshake: address += `4*BURST_LEN`, remaining-to-request -= `BURST_LEN`, go to WAIT.
- **WAIT:** each `rd_data_valid` beat writes `rd_data` into the FIFO and increments a beat counter.
  - Only one burst is outstanding at any time.
  - After `BURST_LEN` beats: go to REQ if remaining-to-request > 0, otherwise go to DRAIN.
- **DRAIN:** wait until remaining-to-pop reaches 0.
- **Pop:** each `display_valid & display_ready` pops one word and decrements remaining-to-pop. Pops are allowed in REQ, WAIT and DRAIN.
- **Frame end:** the pop that takes remaining-to-pop to 0 pulses `frame_done`. On the next cycle `busy` = 0 and the state is IDLE.
- **Ignored inputs:**
  - `rd_data_valid` outside WAIT.
  - `frame_start` while `busy` = 1 or `enable` = 0.
- **Underflow:** `underflow` sets when `busy & display_ready & ~display_valid`. It holds until the next accepted `frame_start`.
- **FIFO:**
  - Push and pop in the same cycle leave `count` unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Overflow cannot occur, because a request is issued only when space for the whole burst exists.
- **Address arithmetic:** modulo 2^32. No alignment checks.
- **Leftover words:** the FIFO is empty at frame end by construction. An accepted `frame_start` also resets the FIFO pointers.

## Timing
- Reset values: `rd_req_valid` = 0, `rd_req_addr` = 0, `rd_req_len` = `BURST_LEN`, `display_valid` = 0, `display_data` = 0, `busy` = 0, `frame_done` = 0, `underflow` = 0, state IDLE, FIFO empty.
- An accepted `frame_start` at edge T gives `busy` and `rd_req_valid` high after T, with `rd_req_addr` = `FB_BASE`.
- A request handshake at edge T means `rd_req_valid` is low after T. The next request is asserted no earlier than one cycle after the last data beat of the current burst.
- A `rd_data` beat captured at edge T makes `display_valid` high and `display_data` equal to that word after T. Latency from beat to display is 1 cycle.
- A pop at edge T presents the next head word after T. `display_valid` drops after T if the FIFO is then empty.
- `frame_done` is high for exactly the cycle after the final pop edge.
- Reset mid-operation:
  - all outputs return to their reset values immediately (asynchronous);
  - an in-flight burst is abandoned;
  - later `rd_data_valid` beats are ignored until a new frame reaches WAIT.

## Test plan
All scenarios use `FB_BASE`=32'h1000, `LINE_WORDS`=4, `BURST_LEN`=4, `FIFO_DEPTH`=8, with memory returning data = address.
1. **Basic frame:** `LINES`=2, memory always ready, `display_ready`=1, `frame_start` → requests at 0x1000 then 0x1010, each with len 4. Eight words 0x1000..0x101C appear in order, then one `frame_done` pulse, then `busy` = 0. `underflow` = 0 if data arrives before `display_ready` is sampled; otherwise it sets.
2. **Display backpressure:** `LINES`=4, `display_ready`=0 → exactly 2 bursts complete, FIFO count = 8, no third request. Popping 4 words triggers the 0x1020 request.
3. **Request stall:** `rd_req_ready` held low for 5 cycles → `rd_req_valid` stays high and `rd_req_addr` stays 0x1000 throughout. The handshake occurs on the 6th cycle.
4. **Underflow:** data delayed 10 cycles after request, `display_ready`=1 → `underflow` = 1 and stays 1 through `frame_done`. It clears on the next accepted `frame_start`.
5. **Ignored starts:** `frame_start` while `busy`, and `frame_start` with `enable` = 0 → no new request, no address reload, word sequence unchanged.
6. **Reset mid-burst:** assert `reset_n` = 0 after 2 of 4 beats → all outputs reset. Stray beats are ignored. A new `frame_start` requests 0x1000 and delivers a correct full frame.
